// File: rtl/vnu_sched_if.sv
// Memory-side and check-node-side bus of the variable-node sequencer.
// The master is the sequencer; the slave is the message memory / CNU side.
interface vnu_sched_if #(
   parameter int N      = 16,
   parameter int ADDR_W = 4,
   parameter int D      = 3,
   parameter int data_w = 6,
   parameter int ext_w  = 3
);
   localparam int sum_w = data_w + ext_w;

   logic                    rd_en;
   logic [ADDR_W-1:0]       rd_addr;
   logic [data_w-1:0]       l_in;
   logic [data_w*D-1:0]     r_in;
   logic                    wr_en;
   logic [ADDR_W-1:0]       wr_addr;
   logic [sum_w*D-1:0]      q_out;
   logic [N-1:0]            dec_vec;
   logic                    cnu_start;
   logic                    cnu_done;
   logic                    syndrome_ok;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, q_out, dec_vec, cnu_start,
      input  l_in, r_in, cnu_done, syndrome_ok
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, q_out, dec_vec, cnu_start,
      output l_in, r_in, cnu_done, syndrome_ok
   );
endinterface

// File: rtl/vnu_sched.sv
// Variable-node datapath and the sequencer that time-multiplexes it over all
// N nodes, alternating with the check-node phase until the syndrome passes
// or the iteration limit is hit.

// Combinational variable-node update: s = l + sum(r), q_i = s - r_i.
module vnu #(
   parameter int D      = 3,
   parameter int data_w = 6,
   parameter int ext_w  = 3
) (
   input  logic [data_w-1:0]                l,
   input  logic [data_w*D-1:0]              r,
   output logic [(data_w+ext_w)*D-1:0]      q,
   output logic                             dec
);
   localparam int sum_w = data_w + ext_w;

   logic [sum_w-1:0] rx [D];
   logic [sum_w-1:0] s;

   // Sign-extend every input, form the total and the extrinsic outputs.
   always_comb begin
      s = {{ext_w{l[data_w-1]}}, l};
      q = '0;
      for (int unsigned i = 0; i < D; i++) begin
         rx[i] = {{ext_w{r[i*data_w + data_w - 1]}}, r[i*data_w +: data_w]};
         s     = s + rx[i];
      end
      for (int unsigned i = 0; i < D; i++)
         q[i*sum_w +: sum_w] = s - rx[i];
      dec = s[sum_w-1];
   end
endmodule

module vnu_sched #(
   parameter int N        = 16,
   parameter int ADDR_W   = 4,
   parameter int D        = 3,
   parameter int data_w   = 6,
   parameter int ext_w    = 3,
   parameter int MAX_ITER = 8,
   parameter int IT_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             converged,
   output logic [IT_W-1:0]  iter_cnt,
   vnu_sched_if.master      bus
);
   localparam int sum_w = data_w + ext_w;

   typedef enum logic [2:0] {IDLE, SWEEP, DRAIN, CNU, DONE} state_t;

   state_t              state;
   logic                drain_cnt;
   logic                rd_en_q;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic                cnu_start_q;
   logic [IT_W-1:0]     iter_nxt;

   logic                d_en;
   logic [ADDR_W-1:0]   d_addr;
   logic                wr_en_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [sum_w*D-1:0]  q_q;
   logic [N-1:0]        dec_q;

   logic [sum_w*D-1:0]  vq;
   logic                vdec;

   assign iter_nxt      = iter_cnt + 1'b1;

   assign bus.rd_en     = rd_en_q;
   assign bus.rd_addr   = rd_addr_q;
   assign bus.cnu_start = cnu_start_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.q_out     = q_q;
   assign bus.dec_vec   = dec_q;

   vnu #(.D(D), .data_w(data_w), .ext_w(ext_w)) u_vnu (
      .l   (bus.l_in),
      .r   (bus.r_in),
      .q   (vq),
      .dec (vdec)
   );

   // Decode controller: sweep, drain, check-node handshake, iteration control.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         drain_cnt   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         converged   <= 1'b0;
         iter_cnt    <= '0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         cnu_start_q <= 1'b0;
      end else begin
         done        <= 1'b0;
         cnu_start_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= SWEEP;
                  busy      <= 1'b1;
                  iter_cnt  <= '0;
                  converged <= 1'b0;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= '0;
               end
            end
            SWEEP: begin
               if (rd_addr_q == ADDR_W'(N - 1)) begin
                  rd_en_q   <= 1'b0;
                  drain_cnt <= 1'b0;
                  state     <= DRAIN;
               end else begin
                  rd_addr_q <= rd_addr_q + 1'b1;
               end
            end
            DRAIN: begin
               if (drain_cnt) begin
                  state       <= CNU;
                  cnu_start_q <= 1'b1;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            CNU: begin
               // cnu_start_q is high only in the first CNU cycle, which
               // doubles as the "ignore cnu_done" qualifier.
               if (!cnu_start_q && bus.cnu_done) begin
                  iter_cnt <= iter_nxt;
                  if (bus.syndrome_ok) begin
                     converged <= 1'b1;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= DONE;
                  end else if (iter_nxt == IT_W'(MAX_ITER)) begin
                     converged <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state     <= SWEEP;
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= '0;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Two-stage read-to-write pipeline: align address with returned data,
   // then register vnu results and the per-node hard decision.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_en      <= 1'b0;
         d_addr    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         q_q       <= '0;
         dec_q     <= '0;
      end else begin
         d_en      <= rd_en_q;
         d_addr    <= rd_addr_q;
         wr_en_q   <= d_en;
         wr_addr_q <= d_addr;
         if (d_en) begin
            q_q           <= vq;
            dec_q[d_addr] <= vdec;
         end
      end
   end
endmodule

// File: tb/tb_vnu_sched.sv
// Randomised scoreboard bench for vnu_sched: a memory model serves reads,
// a reference model predicts every write, and per-decode event schedules
// are derived from the cycle rules of the sequencer.
module tb_vnu_sched;
   localparam int N        = 4;
   localparam int ADDR_W   = 2;
   localparam int D        = 3;
   localparam int DW       = 6;
   localparam int EW       = 3;
   localparam int SW       = DW + EW;
   localparam int MAX_ITER = 2;
   localparam int IT_W     = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             busy;
   logic             done;
   logic             converged;
   logic [IT_W-1:0]  iter_cnt;

   int checks = 0;
   int errors = 0;

   int lmem [N];
   int rmem [N][D];

   typedef struct {
      int               addr;
      logic [SW*D-1:0]  q;
      logic             dec;
   } exp_t;

   exp_t exp_q [$];

   vnu_sched_if #(.N(N), .ADDR_W(ADDR_W), .D(D), .data_w(DW), .ext_w(EW)) bus ();

   vnu_sched #(
      .N(N), .ADDR_W(ADDR_W), .D(D), .data_w(DW), .ext_w(EW),
      .MAX_ITER(MAX_ITER), .IT_W(IT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .converged (converged),
      .iter_cnt  (iter_cnt),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: integer sums straight from the node's stored messages.
   function automatic exp_t model(input int a);
      exp_t e;
      int   s;
      s = lmem[a];
      for (int i = 0; i < D; i++) s += rmem[a][i];
      e.addr = a;
      e.q    = '0;
      for (int i = 0; i < D; i++) e.q[i*SW +: SW] = SW'(s - rmem[a][i]);
      e.dec  = (s < 0);
      return e;
   endfunction

   // Memory: data for a read seen in one cycle is presented in the next.
   initial begin : mem_model
      bit pend;
      int pa;
      pend = 1'b0;
      pa = 0;
      bus.l_in = '0;
      bus.r_in = '0;
      forever begin
         @(negedge clk);
         if (pend) begin
            bus.l_in = DW'(lmem[pa]);
            for (int i = 0; i < D; i++) bus.r_in[i*DW +: DW] = DW'(rmem[pa][i]);
         end
         pend = bus.rd_en;
         pa   = int'(bus.rd_addr);
      end
   end

   // Scoreboard: reads push predictions, writes pop and compare.
   initial begin : scoreboard
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.wr_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wr_unexpected: got write addr %0d expected no write", bus.wr_addr);
            end else begin
               e = exp_q.pop_front();
               chk("sb_wr_addr", bus.wr_addr, e.addr);
               chk("sb_q_out", bus.q_out, e.q);
               chk("sb_dec", bus.dec_vec[bus.wr_addr], e.dec);
            end
         end
         if (bus.rd_en) exp_q.push_back(model(int'(bus.rd_addr)));
      end
   end

   task automatic randomize_mem();
      for (int a = 0; a < N; a++) begin
         lmem[a] = int'($urandom_range(63)) - 32;
         for (int i = 0; i < D; i++) rmem[a][i] = int'($urandom_range(63)) - 32;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_conv"}, converged, 0);
      chk({tag, "_iter"}, iter_cnt, 0);
      chk({tag, "_rd_en"}, bus.rd_en, 0);
      chk({tag, "_rd_addr"}, bus.rd_addr, 0);
      chk({tag, "_wr_en"}, bus.wr_en, 0);
      chk({tag, "_wr_addr"}, bus.wr_addr, 0);
      chk({tag, "_q_out"}, bus.q_out, 0);
      chk({tag, "_dec_vec"}, bus.dec_vec, 0);
      chk({tag, "_cnu_start"}, bus.cnu_start, 0);
   endtask

   // One full decode. Cycle k is the period following edge k-1, start is
   // sampled at edge 0. pass_iter: iteration whose syndrome passes (0 = never).
   task automatic run_decode(input int pass_iter, input bit glitch, input bit mid_start, input int fixed_dly);
      int  exp_rd [256];
      int  exp_wr [256];
      bit  exp_cs [256];
      int  cd_at  [256];
      int  s, p, c, done_exp, it_exp;
      bit  cv_exp, synd;
      for (int i = 0; i < 256; i++) begin
         exp_rd[i] = -1; exp_wr[i] = -1; exp_cs[i] = 1'b0; cd_at[i] = -1;
      end
      s = 1; done_exp = 0; it_exp = 0; cv_exp = 1'b0;
      for (int j = 1; j <= MAX_ITER; j++) begin
         for (int k = 0; k < N; k++) begin
            exp_rd[s + k]     = k;
            exp_wr[s + 2 + k] = k;
         end
         p = s + N + 2;
         exp_cs[p] = 1'b1;
         c = p + ((fixed_dly > 0) ? fixed_dly : int'($urandom_range(5, 1)));
         synd = (j == pass_iter);
         cd_at[c] = synd ? 1 : 0;
         if (synd || j == MAX_ITER) begin
            done_exp = c + 1; it_exp = j; cv_exp = synd;
            break;
         end
         s = c + 1;
      end

      @(negedge clk);
      start = 1'b1;
      bus.cnu_done = 1'b0;
      for (int rel = 1; rel <= done_exp + 2; rel++) begin
         @(negedge clk);
         chk("rd_en", bus.rd_en, exp_rd[rel] >= 0);
         if (exp_rd[rel] >= 0) chk("rd_addr", bus.rd_addr, exp_rd[rel]);
         chk("wr_en", bus.wr_en, exp_wr[rel] >= 0);
         if (exp_wr[rel] >= 0) chk("wr_addr", bus.wr_addr, exp_wr[rel]);
         chk("cnu_start", bus.cnu_start, exp_cs[rel]);
         chk("busy", busy, rel < done_exp);
         chk("done", done, rel == done_exp);
         if (rel >= done_exp) begin
            chk("iter_cnt", iter_cnt, it_exp);
            chk("converged", converged, cv_exp);
         end
         start = mid_start && (rel == 2);
         if (cd_at[rel] >= 0) begin
            bus.cnu_done    = 1'b1;
            bus.syndrome_ok = (cd_at[rel] == 1);
         end else if (glitch && exp_cs[rel]) begin
            bus.cnu_done    = 1'b1;
            bus.syndrome_ok = 1'b1;
         end else begin
            bus.cnu_done    = 1'b0;
            bus.syndrome_ok = $urandom_range(1);
         end
      end
      bus.cnu_done = 1'b0;
      start = 1'b0;
   endtask

   initial begin : main
      rst = 1'b1;
      start = 1'b0;
      bus.cnu_done = 1'b0;
      bus.syndrome_ok = 1'b0;
      randomize_mem();
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      // Directed arithmetic nodes; node 3 stays random.
      lmem[0] = 5;   rmem[0][0] = -2;  rmem[0][1] = 3;   rmem[0][2] = 1;
      lmem[1] = -20; rmem[1][0] = -10; rmem[1][1] = -10; rmem[1][2] = -10;
      lmem[2] = 31;  rmem[2][0] = 31;  rmem[2][1] = 31;  rmem[2][2] = 31;

      // cnu_done while idle must not wake the sequencer.
      @(negedge clk);
      bus.cnu_done = 1'b1;
      bus.syndrome_ok = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("idle_cnu_busy", busy, 0);
         chk("idle_cnu_done", done, 0);
      end
      bus.cnu_done = 1'b0;
      @(negedge clk);
      chk("idle_cnu_done2", done, 0);

      // Early termination 5 cycles after cnu_start, with a stray start and
      // a cnu_done in the cnu_start cycle.
      run_decode(1, 1'b1, 1'b1, 5);

      // Iteration limit.
      randomize_mem();
      run_decode(0, 1'b0, 1'b0, 0);

      // Reset during a sweep.
      randomize_mem();
      @(negedge clk);
      start = 1'b1;
      for (int rel = 1; rel <= 3; rel++) begin
         @(negedge clk);
         start = 1'b0;
         if (rel == 3) rst = 1'b1;
      end
      @(negedge clk);
      chk_all_zero("midrst");
      rst = 1'b0;
      exp_q.delete();
      repeat (6) begin
         @(negedge clk);
         chk("post_rst_wr_en", bus.wr_en, 0);
         chk("post_rst_rd_en", bus.rd_en, 0);
      end

      // Random decodes after the reset.
      for (int n = 0; n < 5; n++) begin
         randomize_mem();
         run_decode(int'($urandom_range(MAX_ITER)), 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
      end

      repeat (3) @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
